// File: rtl/pipeline_register_elastic.sv
// rtl/pipeline_register_elastic.sv - elastic pipeline register with optional skid entry, flush and flush counter
module pipeline_register_elastic #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  flush_count
);

   // State value doubles as the number of held entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   // Main entry drives the output; skid entry absorbs the beat accepted while stalled.
   logic [DATA_W-1:0]  main_data_q;
   logic [CTRL_W-1:0]  main_ctrl_q;
   logic [DATA_W-1:0]  skid_data_q;
   logic [CTRL_W-1:0]  skid_ctrl_q;

   // Registered copy of "skid entry free" so in_ready has no path from out_ready.
   logic               skid_free_q;

   logic               in_xfer;
   logic               out_xfer;
   logic               load_main_in;
   logic               load_skid_in;
   logic               move_skid;
   logic [1:0]         flush_drop;

   logic [CNT_W-1:0]   flush_count_q;
   logic [CNT_W:0]     flush_sum;

   assign out_valid   = (state_q != ST_EMPTY);
   assign occupancy   = state_q;
   assign out_data    = main_data_q;
   assign out_ctrl    = main_ctrl_q & {CTRL_W{out_valid}};
   assign flush_count = flush_count_q;
   assign in_xfer     = in_valid && in_ready;
   assign out_xfer    = out_valid && out_ready;

   // Ready: registered skid-free flag with a skid entry, otherwise pass-through of downstream ready.
   always_comb begin
      in_ready = 1'b1;
      if (SKID != 0) begin
         in_ready = skid_free_q;
      end else begin
         in_ready = !out_valid || out_ready;
      end
   end

   // Next-state and datapath steering; flush overrides every other transition.
   always_comb begin
      state_d      = state_q;
      load_main_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
      flush_drop   = 2'd0;
      if (flush) begin
         state_d    = ST_EMPTY;
         // An entry leaving downstream this cycle is delivered, not discarded.
         flush_drop = 2'(state_q) - {1'b0, out_xfer};
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  load_main_in = 1'b1;
                  state_d      = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  load_main_in = 1'b1;
               end else if (in_xfer) begin
                  if (SKID != 0) begin
                     load_skid_in = 1'b1;
                     state_d      = ST_FULL;
                  end
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  move_skid = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Saturating add of the discarded-entry count.
   always_comb begin
      flush_sum = {1'b0, flush_count_q} + (CNT_W+1)'(flush_drop);
   end

   // State, ready flag and entry registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         skid_free_q <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         skid_free_q <= (state_d != ST_FULL);
         if (load_main_in) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
         end else if (move_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
         end
         if (load_skid_in) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
         end
      end
   end

   // Flush counter clamps at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_count_q <= '0;
      end else if (flush_sum[CNT_W]) begin
         flush_count_q <= '1;
      end else begin
         flush_count_q <= flush_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// tb/tb_pipeline_register_elastic.sv - randomized and directed bench for pipeline_register_elastic
module tb_pipeline_register_elastic;

   localparam int DW = 69;
   localparam int CW = 8;
   localparam int EW = DW + CW;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          rdy [3];
   logic          ov  [3];
   logic [DW-1:0] od  [3];
   logic [CW-1:0] oc  [3];
   logic [1:0]    occ [3];
   logic [15:0]   fc0;
   logic [15:0]   fc1;
   logic [1:0]    fc2;

   int tests = 0;
   int fails = 0;

   // Reference model: per instance a FIFO of up to two {ctrl,data} entries.
   int            mn    [3];
   logic [EW-1:0] ment  [3][2];
   logic [DW-1:0] mlast [3];
   int            mcnt  [3];

   always #5 clk = ~clk;

   // Instance 0: skid, 16-bit counter. Instance 1: no skid. Instance 2: skid, 2-bit counter.
   pipeline_register_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_skid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
      .occupancy(occ[0]), .flush_count(fc0));

   pipeline_register_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_noskid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
      .occupancy(occ[1]), .flush_count(fc1));

   pipeline_register_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(2)) u_cnt2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]),
      .occupancy(occ[2]), .flush_count(fc2));

   function automatic bit has_skid(int i);
      return i != 1;
   endfunction

   function automatic int cnt_max(int i);
      return (i == 2) ? 3 : 65535;
   endfunction

   function automatic int get_fc(int i);
      if (i == 0) return int'(fc0);
      if (i == 1) return int'(fc1);
      return int'(fc2);
   endfunction

   function automatic logic exp_rdy(int i);
      if (has_skid(i)) return mn[i] < 2;
      return (mn[i] == 0) || out_ready;
   endfunction

   function automatic logic [DW-1:0] exp_data(int i);
      if (mn[i] > 0) return ment[i][0][DW-1:0];
      return mlast[i];
   endfunction

   function automatic logic [CW-1:0] exp_ctrl(int i);
      if (mn[i] > 0) return ment[i][0][EW-1:DW];
      return '0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mn[i]    = 0;
         mlast[i] = '0;
         mcnt[i]  = 0;
      end
   endtask

   // Applies one clock edge of the handshake/flush rules to every model instance.
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         logic ix;
         logic ox;
         int   c;
         ix = in_valid && exp_rdy(i);
         ox = (mn[i] > 0) && out_ready;
         if (flush) begin
            c       = mcnt[i] + mn[i] - int'(ox);
            mcnt[i] = (c > cnt_max(i)) ? cnt_max(i) : c;
            mn[i]   = 0;
         end else begin
            if (ox) begin
               ment[i][0] = ment[i][1];
               mn[i]      = mn[i] - 1;
            end
            if (ix) begin
               ment[i][mn[i]] = {in_ctrl, in_data};
               mn[i]          = mn[i] + 1;
            end
            if (mn[i] > 0) mlast[i] = ment[i][0][DW-1:0];
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (rdy[i] !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready_during[%0d] got %b expected 1", i, rdy[i]);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (ov[i] !== 1'b0 || oc[i] !== '0 || occ[i] !== 2'd0 || rdy[i] !== 1'b1 ||
             od[i] !== '0 || get_fc(i) !== 0) begin
            fails++;
            $display("FAIL reset_state[%0d] got ov=%b oc=%h occ=%0d rdy=%b od=%h fc=%0d expected 0,0,0,1,0,0",
                     i, ov[i], oc[i], occ[i], rdy[i], od[i], get_fc(i));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_throughput();
      apply_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 8'h05;
      for (int k = 1; k <= 8; k++) begin
         in_data = DW'(k);
         tick();
         tests++;
         if (ov[0] !== 1'b1 || od[0] !== DW'(k) || occ[0] !== 2'd1 || oc[0] !== 8'h05) begin
            fails++;
            $display("FAIL throughput_beat%0d got ov=%b od=%0h occ=%0d oc=%h expected 1,%0h,1,05",
                     k, ov[0], od[0], occ[0], oc[0], k);
         end
      end
      in_valid = 1'b0;
      tick();
      tests++;
      if (ov[0] !== 1'b0 || occ[0] !== 2'd0) begin
         fails++;
         $display("FAIL throughput_drain got ov=%b occ=%0d expected 0,0", ov[0], occ[0]);
      end
   endtask

   task automatic test_skid_fill();
      apply_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'h11);
      in_ctrl   = 8'h3c;
      tick();
      tests++;
      if (occ[0] !== 2'd1 || rdy[0] !== 1'b1 || od[0] !== DW'(32'h11)) begin
         fails++;
         $display("FAIL skid_first got occ=%0d rdy=%b od=%h expected 1,1,11", occ[0], rdy[0], od[0]);
      end
      in_data = DW'(32'h22);
      in_ctrl = 8'h5a;
      tick();
      tests++;
      if (occ[0] !== 2'd2 || rdy[0] !== 1'b0 || od[0] !== DW'(32'h11) || oc[0] !== 8'h3c) begin
         fails++;
         $display("FAIL skid_full got occ=%0d rdy=%b od=%h oc=%h expected 2,0,11,3c",
                  occ[0], rdy[0], od[0], oc[0]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tests++;
      if (od[0] !== DW'(32'h22) || oc[0] !== 8'h5a || occ[0] !== 2'd1 || rdy[0] !== 1'b1) begin
         fails++;
         $display("FAIL skid_drain_a got od=%h oc=%h occ=%0d rdy=%b expected 22,5a,1,1",
                  od[0], oc[0], occ[0], rdy[0]);
      end
      tick();
      tests++;
      if (ov[0] !== 1'b0 || occ[0] !== 2'd0 || oc[0] !== 8'h00 || od[0] !== DW'(32'h22)) begin
         fails++;
         $display("FAIL skid_drain_b got ov=%b occ=%0d oc=%h od=%h expected 0,0,00,22",
                  ov[0], occ[0], oc[0], od[0]);
      end
   endtask

   task automatic test_flush_full();
      apply_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 8'hff;
      in_data   = DW'(32'h11);
      tick();
      in_data = DW'(32'h22);
      tick();
      flush   = 1'b1;
      in_data = DW'(32'h33);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (occ[0] !== 2'd0 || ov[0] !== 1'b0 || oc[0] !== 8'h00 || rdy[0] !== 1'b1 || fc0 !== 16'd2) begin
         fails++;
         $display("FAIL flush_full got occ=%0d ov=%b oc=%h rdy=%b fc=%0d expected 0,0,00,1,2",
                  occ[0], ov[0], oc[0], rdy[0], fc0);
      end
      tests++;
      if (fc1 !== 16'd1 || fc2 !== 2'd2) begin
         fails++;
         $display("FAIL flush_full_others got fc1=%0d fc2=%0d expected 1,2", fc1, fc2);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests++;
         if (ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_ghost%0d got ov=%b od=%h expected 0", k, ov[0], od[0]);
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'h44);
      tick();
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = DW'(32'h55);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (fc0 !== 16'd2 || occ[0] !== 2'd0 || ov[0] !== 1'b0) begin
         fails++;
         $display("FAIL flush_with_out got fc=%0d occ=%0d ov=%b expected 2,0,0", fc0, occ[0], ov[0]);
      end
   endtask

   task automatic test_saturate();
      int exp_sat [3];
      exp_sat = '{2, 3, 3};
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = DW'(2 * r + 1);
         tick();
         in_data = DW'(2 * r + 2);
         tick();
         in_valid = 1'b0;
         flush    = 1'b1;
         tick();
         flush = 1'b0;
         tests++;
         if (int'(fc2) !== exp_sat[r] || occ[2] !== 2'd0) begin
            fails++;
            $display("FAIL saturate_round%0d got fc=%0d occ=%0d expected %0d,0", r, fc2, occ[2], exp_sat[r]);
         end
      end
   endtask

   task automatic test_noskid();
      bit pat [3];
      pat = '{1'b1, 1'b0, 1'b1};
      apply_reset();
      in_ctrl  = 8'h81;
      in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         out_ready = pat[c % 3];
         in_data   = DW'(100 + c);
         #1;
         tests++;
         if (rdy[1] !== exp_rdy(1) || ov[1] !== (mn[1] > 0) || oc[1] !== exp_ctrl(1) ||
             occ[1] !== 2'(mn[1]) || (mn[1] > 0 && od[1] !== exp_data(1))) begin
            fails++;
            $display("FAIL noskid_cycle%0d got rdy=%b ov=%b oc=%h occ=%0d od=%0h expected %b,%b,%h,%0d,%0h",
                     c, rdy[1], ov[1], oc[1], occ[1], od[1], exp_rdy(1), mn[1] > 0, exp_ctrl(1), mn[1],
                     exp_data(1));
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'h77);
      tick();
      tick();
      in_valid = 1'b0;
      reset    = 1'b1;
      model_reset();
      #1;
      tests++;
      if (occ[0] !== 2'd0 || ov[0] !== 1'b0 || rdy[0] !== 1'b1 || fc0 !== 16'd0 || oc[0] !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid got occ=%0d ov=%b rdy=%b fc=%0d oc=%h expected 0,0,1,0,00",
                  occ[0], ov[0], rdy[0], fc0, oc[0]);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 99) < 3);
         in_data   = DW'({$urandom, $urandom, $urandom});
         in_ctrl   = CW'($urandom);
         #1;
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (rdy[i] !== exp_rdy(i) || ov[i] !== (mn[i] > 0) || occ[i] !== 2'(mn[i]) ||
                oc[i] !== exp_ctrl(i) || od[i] !== exp_data(i) || get_fc(i) !== mcnt[i]) begin
               fails++;
               $display("FAIL random_c%0d_dut%0d got rdy=%b ov=%b occ=%0d oc=%h od=%h fc=%0d expected %b,%b,%0d,%h,%h,%0d",
                        c, i, rdy[i], ov[i], occ[i], oc[i], od[i], get_fc(i),
                        exp_rdy(i), mn[i] > 0, mn[i], exp_ctrl(i), exp_data(i), mcnt[i]);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_skid_fill();
      test_flush_full();
      test_saturate();
      test_noskid();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_register_elastic.md
Name: pipeline_register_elastic

Overview:
Parametrised, elastic pipeline register for inter-stage boundaries (IF/ID through MEM/WB). It carries a data payload and a control field with a valid/ready handshake. An optional 2-entry skid buffer gives full throughput with a registered in_ready. Synchronous flush inserts bubbles. A saturating counter records the number of flushed entries for performance monitoring.

Parameters:
DATA_W, 69, payload width in bits (e.g. dm 32 + alu 32 + rd 5)
CTRL_W, 8, control width in bits (e.g. regwrite 1 + op 7); forced to 0 on bubbles
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, flush counter width in bits

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
flush  input  1  synchronous discard of all held entries
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  output payload
out_ctrl  output  CTRL_W  output control; 0 whenever out_valid=0
occupancy  output  2  entries held (0..2; max 1 when SKID=0)
flush_count  output  CNT_W  saturating count of entries discarded by flush

Behaviour:
- Reset (async, active-high) clears all state.
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, flush_count=0.
  - in_ready=1 while reset is asserted and on the first cycle after release.
  - Reset mid-transfer drops every held beat without counting it.
- Handshake:
  - Input transfer when in_valid && in_ready at a clk edge.
  - Output transfer when out_valid && out_ready at a clk edge.
  - in_data/in_ctrl are sampled only on an input transfer.
  - out_data and out_ctrl hold stable while out_valid && !out_ready.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N if the block was empty. Strict FIFO order, no reordering or duplication.
- SKID=1 states (occupancy):
  - EMPTY(0) -> ONE on an input transfer.
  - ONE(1), main entry valid:
    - in && !out: -> FULL (beat goes to the skid entry).
    - in && out: stays ONE (main takes the new beat).
    - out only: -> EMPTY.
  - FULL(2), main + skid valid:
    - in_ready=0.
    - out: skid moves to main, -> ONE.
  - in_ready = !(skid entry valid), driven from a register; no combinational path from out_ready.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - occupancy is 0 or 1.
  - Simultaneous in and out: the new beat replaces the old one, so full throughput is kept.
- Flush (synchronous, highest priority):
  - At the edge, all entries are invalidated. occupancy=0, out_valid=0, out_ctrl=0, in_ready=1 next cycle.
  - An input transfer in the same cycle is consumed and discarded. It is not counted.
  - An output transfer in the same cycle completes normally downstream. That entry is not counted as flushed.
  - flush_count += (entries held minus any entry leaving via out_ready that cycle).
  - flush_count saturates at 2^CNT_W-1 and never wraps.
- Bubble gating: out_ctrl = held ctrl & {CTRL_W{out_valid}}, so no stale regwrite reaches writeback. out_data is not gated and holds its last value.
- The block itself never loses or duplicates beats under any mix of in_valid, out_ready or flush.

Test Plan:
- Reset release, no traffic -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, flush_count=0.
- SKID=1, out_ready=1, in_valid=1 every cycle, in_data=1..8 -> out_data=1..8 on consecutive cycles, one-cycle latency, occupancy steady at 1.
- SKID=1, out_ready=0 after beat A=0x11 is accepted, then B=0x22 presented -> B accepted, occupancy=2, in_ready=0. After out_ready=1: A then B emerge in order, in_ready returns to 1 one cycle after the first drain.
- FULL (2 entries) with out_ready=0, flush=1 for one cycle -> occupancy=0, out_valid=0, out_ctrl=0, flush_count=2. Beat presented during the flush cycle is never output.
- CNT_W=2, repeated flushes with 2 entries held each time -> flush_count 2, 3, 3 (saturates).
- SKID=0, in_ctrl=0x81, out_ready toggling 1,0,1 with continuous input -> in_ready tracks !out_valid||out_ready combinationally, output order preserved, out_ctrl=0 on every cycle with out_valid=0.
